// File: rtl/burst_ram_arbiter.sv
// Two-requester whole-line controller in front of BurstRAM: round-robin grant,
// command strobe, write-line serialization and read-burst assembly into rd_line.
`timescale 1ns/1ps
module burst_ram_arbiter #(
  parameter int ADDRESS_BITWIDTH = 32,
  parameter int DATA_BITWIDTH    = 64,
  parameter int BURST_COUNT      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   req0_valid,
  input  logic                                   req1_valid,
  input  logic                                   req0_write,
  input  logic                                   req1_write,
  input  logic [ADDRESS_BITWIDTH-1:0]            req0_addr,
  input  logic [ADDRESS_BITWIDTH-1:0]            req1_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   req0_wr_line,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   req1_wr_line,
  output logic                                   req0_done,
  output logic                                   req1_done,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0]   rd_line,
  output logic                                   ram_cmd,
  output logic                                   ram_cmd_en,
  output logic [ADDRESS_BITWIDTH-1:0]            ram_addr,
  output logic [DATA_BITWIDTH-1:0]               ram_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]             ram_data_mask,
  input  logic [DATA_BITWIDTH-1:0]               ram_rd_data,
  input  logic                                   ram_rd_data_ready,
  input  logic                                   ram_busy
);

  localparam int IW = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int CW = IW + 1;
  localparam int LW = DATA_BITWIDTH * BURST_COUNT;
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_COUNT - 1);
  localparam logic [CW-1:0] ALL_WORDS = CW'(BURST_COUNT);
  localparam logic [ADDRESS_BITWIDTH-1:0] ALIGN_MASK = ~(ADDRESS_BITWIDTH'(BURST_COUNT - 1));

  typedef enum logic [1:0] {IDLE, WRITE_BURST, READ_WAIT, DONE} state_t;

  state_t                      state, state_n;
  logic [CW-1:0]               cnt, cnt_n;
  logic                        gnt, gnt_n;
  logic                        last_gnt, last_n;
  logic [LW-1:0]               line_q, line_n;
  logic                        cmd_en_n, cmd_n, done0_n, done1_n;
  logic [ADDRESS_BITWIDTH-1:0] addr_n;
  logic [DATA_BITWIDTH-1:0]    wr_n;
  logic [LW-1:0]               rd_n;

  logic                        pick, sel_write;
  logic [ADDRESS_BITWIDTH-1:0] sel_addr;
  logic [LW-1:0]               sel_line;

  function automatic logic [DATA_BITWIDTH-1:0] word_of(input logic [LW-1:0] line,
                                                       input logic [IW-1:0] idx);
    return line[int'(idx) * DATA_BITWIDTH +: DATA_BITWIDTH];
  endfunction

  // On a tie the requester not served last wins; otherwise whoever is valid.
  assign pick      = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
  assign sel_write = pick ? req1_write : req0_write;
  assign sel_addr  = pick ? req1_addr : req0_addr;
  assign sel_line  = pick ? req1_wr_line : req0_wr_line;

  assign ram_data_mask = '0;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    gnt_n    = gnt;
    last_n   = last_gnt;
    line_n   = line_q;
    cmd_en_n = 1'b0;
    cmd_n    = ram_cmd;
    addr_n   = ram_addr;
    wr_n     = ram_wr_data;
    done0_n  = 1'b0;
    done1_n  = 1'b0;
    rd_n     = rd_line;
    case (state)
      IDLE: begin
        if (!ram_busy && (req0_valid || req1_valid)) begin
          gnt_n    = pick;
          last_n   = pick;
          line_n   = sel_line;
          cmd_en_n = 1'b1;
          cmd_n    = sel_write;
          addr_n   = sel_addr & ALIGN_MASK;
          if (sel_write) begin
            wr_n    = word_of(sel_line, '0);
            cnt_n   = CW'(1);
            state_n = WRITE_BURST;
          end else begin
            cnt_n   = '0;
            state_n = READ_WAIT;
          end
        end
      end
      WRITE_BURST: begin
        // Counter reaching BURST_COUNT means the last word is on the bus this cycle.
        if (cnt == ALL_WORDS) begin
          state_n = DONE;
          done0_n = ~gnt;
          done1_n = gnt;
        end else begin
          wr_n  = word_of(line_q, cnt[IW-1:0]);
          cnt_n = cnt + 1'b1;
        end
      end
      READ_WAIT: begin
        if (ram_rd_data_ready) begin
          rd_n[int'(cnt[IW-1:0]) * DATA_BITWIDTH +: DATA_BITWIDTH] = ram_rd_data;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_WORD) begin
            state_n = DONE;
            done0_n = ~gnt;
            done1_n = gnt;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      line_q      <= '0;
      ram_cmd_en  <= 1'b0;
      ram_cmd     <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      req0_done   <= 1'b0;
      req1_done   <= 1'b0;
      rd_line     <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      gnt         <= gnt_n;
      last_gnt    <= last_n;
      line_q      <= line_n;
      ram_cmd_en  <= cmd_en_n;
      ram_cmd     <= cmd_n;
      ram_addr    <= addr_n;
      ram_wr_data <= wr_n;
      req0_done   <= done0_n;
      req1_done   <= done1_n;
      rd_line     <= rd_n;
    end
  end

endmodule
